// File: rtl/y_demux_deser.sv
// Serial-to-parallel receiver: shifts MSB-first frames off a 1-bit line and
// steers each completed word to one of two holding registers, flagging aborted frames.
module y_demux_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sync,
    input  logic             chan,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             v0,
    output logic             v1,
    output logic             err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             chan_q, chan_d;
    logic [WIDTH-1:0] out0_d, out1_d;
    logic             v0_d, v1_d, err_d;
    logic [WIDTH-1:0] shifted;
    logic             done;

    assign shifted = {shift_q[WIDTH-2:0], sin};
    // Last bit of a frame arrives when the count is one short of WIDTH and no restart.
    assign done    = (state_q == SHIFT) && !sync && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sync) state_d = SHIFT;
            SHIFT:   if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        out0_d  = out0;
        out1_d  = out1;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        err_d   = 1'b0;
        if (sync) begin
            // A sync always starts a new frame; mid-frame it also aborts the old one.
            shift_d = WIDTH'(sin);
            cnt_d   = CW'(1);
            chan_d  = chan;
            err_d   = (state_q == SHIFT);
        end else if (state_q == SHIFT) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CW'(1);
            if (done) begin
                cnt_d = '0;
                if (chan_q) begin
                    out1_d = shifted;
                    v1_d   = 1'b1;
                end else begin
                    out0_d = shifted;
                    v0_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            chan_q  <= 1'b0;
            out0    <= '0;
            out1    <= '0;
            v0      <= 1'b0;
            v1      <= 1'b0;
            err     <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            out0    <= out0_d;
            out1    <= out1_d;
            v0      <= v0_d;
            v1      <= v1_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_y_demux_deser.sv
// Bench for y_demux_deser: queue-based frame model checked every cycle,
// plus literal expectations pinned to specific cycles.
module tb_y_demux_deser;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sin = 1'b0;
    logic         sync = 1'b0;
    logic         chan = 1'b0;
    logic [W-1:0] out0, out1;
    logic         v0, v1, err;

    y_demux_deser #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .sin  (sin),
        .sync (sync),
        .chan (chan),
        .out0 (out0),
        .out1 (out1),
        .v0   (v0),
        .v1   (v1),
        .err  (err)
    );

    initial forever #5 clk = ~clk;

    // Reference model: frame bits collected in a queue, word formed when W bits are in.
    logic [W-1:0] m_out0, m_out1;
    logic         m_v0, m_v1, m_err;
    bit           m_valid = 1'b0;
    bit           in_frame = 1'b0;
    logic         fchan = 1'b0;
    logic         bits[$];
    int           cyc = 0;

    always @(posedge clk) begin
        logic [W-1:0] word;
        cyc++;
        if (reset === 1'b1) begin
            m_out0 = '0; m_out1 = '0;
            m_v0 = 1'b0; m_v1 = 1'b0; m_err = 1'b0;
            in_frame = 1'b0;
            bits.delete();
            m_valid = 1'b1;
        end else begin
            m_v0 = 1'b0; m_v1 = 1'b0; m_err = 1'b0;
            if (sync) begin
                if (in_frame) m_err = 1'b1;
                bits.delete();
                bits.push_back(sin);
                fchan = chan;
                in_frame = 1'b1;
            end else if (in_frame) begin
                bits.push_back(sin);
            end
            if (in_frame && bits.size() == W) begin
                word = '0;
                foreach (bits[i]) word = {word[W-2:0], bits[i]};
                if (fchan) begin m_out1 = word; m_v1 = 1'b1; end
                else       begin m_out0 = word; m_v0 = 1'b1; end
                in_frame = 1'b0;
                bits.delete();
            end
        end
    end

    // Literal expectations: signal id 0=out0 1=out1 2=v0 3=v1 4=err
    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
    } pin_t;
    pin_t pins[$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("out0", 32'(out0), 32'(m_out0));
            chk("out1", 32'(out1), 32'(m_out1));
            chk("v0",   32'(v0),   32'(m_v0));
            chk("v1",   32'(v1),   32'(m_v1));
            chk("err",  32'(err),  32'(m_err));
            chk("v0_v1_excl",  32'(v0 & v1), 32'(0));
            chk("err_v_excl",  32'(err & (v0 | v1)), 32'(0));
        end
        while (pins.size() > 0 && pins[0].at <= cyc) begin
            pin_t p;
            p = pins.pop_front();
            case (p.sig)
                0: chk("pin_out0", 32'(out0), p.val);
                1: chk("pin_out1", 32'(out1), p.val);
                2: chk("pin_v0",   32'(v0),   p.val);
                3: chk("pin_v1",   32'(v1),   p.val);
                default: chk("pin_err", 32'(err), p.val);
            endcase
        end
    end

    task automatic step(input logic r, input logic s, input logic c, input logic d);
        reset = r; sync = s; chan = c; sin = d;
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input int sig, input logic [31:0] val);
        pin_t p;
        p.at = cyc; p.sig = sig; p.val = val;
        pins.push_back(p);
    endtask

    task automatic send_word(input logic c, input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) step(1'b0, (i == W - 1), c, w[i]);
    endtask

    initial begin
        logic [W-1:0] ff;
        ff = '1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pin(0, 32'h0); pin(1, 32'h0); pin(2, 32'h0); pin(3, 32'h0); pin(4, 32'h0);

        // Frame A5 to channel 0, then back-to-back 3C to channel 1.
        send_word(1'b0, 8'hA5);
        pin(0, 32'hA5); pin(2, 32'h1); pin(1, 32'h0); pin(4, 32'h0);
        send_word(1'b1, 8'h3C);
        pin(1, 32'h3C); pin(3, 32'h1); pin(0, 32'hA5); pin(2, 32'h0); pin(4, 32'h0);

        // Early sync aborts a channel-0 frame; new channel-1 frame completes.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        pin(4, 32'h1); pin(2, 32'h0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, ff[i]);
        pin(1, 32'hFF); pin(3, 32'h1); pin(0, 32'hA5); pin(4, 32'h0);

        // Reset mid-frame clears everything; a later frame still lands.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        pin(0, 32'h0); pin(1, 32'h0); pin(2, 32'h0); pin(3, 32'h0); pin(4, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pin(3, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(1'b1, 8'h81);
        pin(1, 32'h81); pin(3, 32'h1);

        // Idle with noisy sin/chan: nothing may change.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            pin(3, 32'h0); pin(4, 32'h0);
        end
        pin(1, 32'h81); pin(0, 32'h0);

        // Reset wins over a simultaneous sync; following bits are ignored.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            pin(3, 32'h0);
        end
        pin(1, 32'h0);

        // Random traffic with aborts, back-to-back frames and rare resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(149) == 0), ($urandom_range(5) == 0),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
